data_mem_responder: RTL and testbench

//  Word-organised data memory that acts as the responder end of the core's data access

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory responder with programmable access latency.
// One request in flight; response held under backpressure.
module data_mem_responder #(
  parameter int          DEPTH     = 4096,
  parameter int          LATENCY   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]  cnt, cnt_nx;
  logic [29:0] addr_q;
  logic [3:0]  we_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        commit;
  logic [29:0] c_addr;
  logic [3:0]  c_we;
  logic [31:0] c_wdata;
  logic [29:0] word_off;
  logic        in_range;
  logic [AW-1:0] widx;

  logic [31:0] mem [DEPTH];

  // Byte offset within a word carries no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign accept     = req_valid && (state == IDLE);
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // With single-cycle latency the commit happens on the accept edge itself.
  always_comb begin
    c_addr  = addr_q;
    c_we    = we_q;
    c_wdata = wdata_q;
    if (state == IDLE) begin
      c_addr  = req_addr[31:2];
      c_we    = req_we;
      c_wdata = req_wdata;
    end
  end

  // BASE_ADDR is word aligned, so the word offset needs only the upper bits.
  assign word_off = c_addr - BASE_ADDR[31:2];
  assign in_range = (word_off < 30'(DEPTH));
  assign widx     = word_off[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= req_addr[31:2];
        we_q    <= req_we;
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= !in_range;
      resp_rdata <= (in_range && c_we == 4'b0) ? mem[widx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (c_we[i]) mem[widx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a word-array reference.
// A second instance covers single-cycle latency and a non-zero base address.
module tb_data_mem_responder;

  localparam int DEPTH_M = 4096;
  localparam int LAT_M   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_we;

  logic        req_valid_b, req_ready_b, resp_valid_b, resp_ready_b;
  logic        resp_err_b, busy_b;
  logic [31:0] req_addr_b, req_wdata_b, resp_rdata_b;
  logic [3:0]  req_we_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl   [16];
  logic [31:0] mdl_b [16];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH_M), .LATENCY(LAT_M), .BASE_ADDR(32'h0)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.DEPTH(16), .LATENCY(1), .BASE_ADDR(32'h100)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_we(req_we_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: applies the request to the word array, returns the response.
  task automatic model(input logic [31:0] a, input logic [3:0] we,
                       input logic [31:0] wd, output logic [31:0] er,
                       output logic ee);
    int w;
    er = 32'h0;
    ee = !(a < 4 * DEPTH_M);
    if (!ee) begin
      w = int'(a[31:2]);
      if (we == 4'b0) er = mdl[w];
      else
        for (int i = 0; i < 4; i++)
          if (we[i]) mdl[w][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input int hold);
    logic [31:0] er;
    logic        ee;
    int          n;
    int          lat;
    model(a, we, wd, er, ee);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_addr  = $urandom;
    req_we    = 4'($urandom);
    req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      chk("wait_busy", busy, 1);
      chk("wait_rdy", req_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, LAT_M);
    chk("err", resp_err, ee);
    chk("rdata", resp_rdata, er);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, er);
      chk("hold_err", resp_err, ee);
      chk("hold_rdy", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("rel_valid", resp_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_rdy", req_ready, 1);
  endtask

  initial begin
    logic [31:0] a, wd, er;
    logic [3:0]  we;
    logic        ee;
    int          n;

    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
    resp_ready = 1'b0;
    req_valid_b = 1'b0; req_addr_b = '0; req_we_b = '0; req_wdata_b = '0;
    resp_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_ready, 1);
    chk("rst_b_rdy", req_ready_b, 1);
    chk("rst_b_valid", resp_valid_b, 0);

    for (int w = 0; w < 16; w++)
      do_req(32'(w * 4), 4'hF, (w == 5) ? 32'hA1B2C3D4 : $urandom, 0);

    do_req(32'h14, 4'b0000, 32'h0, 0);
    do_req(32'h14, 4'b0100, 32'h00EE0000, 0);
    do_req(32'h14, 4'b0000, 32'h0, 0);
    chk("lane_merge", mdl[5], 32'hA1EEC3D4);
    do_req(32'h14, 4'b0000, 32'h0, 5);

    do_req(32'(4 * DEPTH_M), 4'b0000, 32'h0, 0);
    do_req(32'(4 * DEPTH_M), 4'hF, 32'hFFFFFFFF, 1);
    do_req(32'hFFFFFFFC, 4'hF, 32'h5A5A5A5A, 0);
    do_req(32'h0, 4'b0000, 32'h0, 0);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0)
        a = $urandom_range(32'h4000, 32'hFFFFFFFF);
      else
        a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      we = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
      do_req(a, we, $urandom, $urandom_range(0, 3));
    end

    // Reset while a store waits: the store must not land.
    do_req(32'h14, 4'hF, 32'h12345678, 0);
    do_req(32'h14, 4'b0000, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1C; req_we = 4'hF;
    req_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("r5_busy_pre", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("r5_valid", resp_valid, 0);
    chk("r5_busy", busy, 0);
    chk("r5_rdata", resp_rdata, 0);
    chk("r5_err", resp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h1C, 4'b0000, 32'h0, 0);

    // Reset while the response is pending: the store already landed.
    model(32'h20, 4'hF, 32'hCAFEF00D, er, ee);
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_we = 4'hF;
    req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("r6_valid_pre", resp_valid, 1);
    #1 rst = 1'b1;
    #1 chk("r6_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    do_req(32'h20, 4'b0000, 32'h0, 0);

    // Single-cycle latency instance, request held continuously.
    begin
      logic [31:0] oa [8];
      logic [3:0]  owe [8];
      logic [31:0] owd [8];
      logic [31:0] xr;
      logic        xe;
      int          idx;
      for (int i = 0; i < 3; i++) begin
        oa[i] = 32'h100 + 32'(4 * i); owe[i] = 4'hF; owd[i] = $urandom;
        oa[i+3] = 32'h100 + 32'(4 * i) + 32'($urandom_range(0, 3));
        owe[i+3] = 4'h0; owd[i+3] = $urandom;
      end
      oa[6] = 32'hFC;  owe[6] = 4'h0; owd[6] = 32'h0;
      oa[7] = 32'h140; owe[7] = 4'h0; owd[7] = 32'h0;
      xr = 32'h0; xe = 1'b0;
      @(negedge clk);
      req_valid_b = 1'b1;
      resp_ready_b = 1'b1;
      for (int e = 0; e < 16; e++) begin
        chk("b_accept", req_ready_b, 32'(e % 2 == 0));
        chk("b_rvalid", resp_valid_b, 32'(e % 2 == 1));
        if (e % 2 == 1) begin
          chk("b_rdata", resp_rdata_b, xr);
          chk("b_err", resp_err_b, xe);
        end else begin
          idx = e / 2;
          req_addr_b = oa[idx]; req_we_b = owe[idx]; req_wdata_b = owd[idx];
          xr = 32'h0;
          xe = !(oa[idx] >= 32'h100 && oa[idx] < 32'h140);
          if (!xe) begin
            if (owe[idx] == 4'h0) xr = mdl_b[(oa[idx] - 32'h100) >> 2];
            else mdl_b[(oa[idx] - 32'h100) >> 2] = owd[idx];
          end
        end
        @(negedge clk);
      end
      req_valid_b = 1'b0;
      resp_ready_b = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
